// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: multi-lane, two-stage pipelined saturating adder/subtractor.
// Each transfer carries LANES independent WIDTH-bit operand pairs together with
// their own mode bits (addsub, tc, sat), so the mode may change every transfer.
// Stage 1 registers the raw (WIDTH+1)-bit sum/difference and the operand MSBs.
// Stage 2 derives the overflow flags, carry and clamped result, and registers
// them as the outputs. A valid/ready handshake buffers at most two transfers.
// Optional feature: define SAT_STICKY_EN to build per-lane sticky overflow
// latches; when it is undefined, sticky reads 0 and sticky_clr is ignored.
module sat_addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   addsub,
  input  logic                   tc,
  input  logic                   sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] sum,
  output logic [LANES-1:0]       carry,
  output logic [LANES-1:0]       ovf_pos,
  output logic [LANES-1:0]       ovf_neg,
  output logic [LANES-1:0]       sticky,
  input  logic                   sticky_clr
);

  localparam logic [WIDTH-1:0] TC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] TC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1 state
  logic                    s1_valid;
  logic [LANES-1:0][WIDTH:0] s1_raw;
  logic [LANES-1:0]        s1_a_msb;
  logic [LANES-1:0]        s1_b_msb;
  logic                    s1_addsub;
  logic                    s1_tc;
  logic                    s1_sat;

  // Combinational next values
  logic [LANES-1:0][WIDTH:0] raw_next;
  logic [LANES-1:0]        a_msb;
  logic [LANES-1:0]        b_msb;
  logic [LANES*WIDTH-1:0]  sum_next;
  logic [LANES-1:0]        carry_next;
  logic [LANES-1:0]        pos_next;
  logic [LANES-1:0]        neg_next;

  logic adv2;

  // The output stage may load whenever it is empty or being drained; stage 1
  // may load whenever it is empty or can hand its data on.
  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;

  // Per-lane raw sum or difference; subtraction is a + ~b + 1
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    raw_next = '0;
    a_msb    = '0;
    b_msb    = '0;
    for (int i = 0; i < LANES; i++) begin
      a_msb[i] = a[i*WIDTH+WIDTH-1];
      b_msb[i] = b[i*WIDTH+WIDTH-1];
      if (addsub)
        raw_next[i] = {1'b0, a[i*WIDTH +: WIDTH]} + {1'b0, ~b[i*WIDTH +: WIDTH]}
                    + (WIDTH+1)'(1);
      else
        raw_next[i] = {1'b0, a[i*WIDTH +: WIDTH]} + {1'b0, b[i*WIDTH +: WIDTH]};
    end
  end

  // Per-lane overflow flags, carry/borrow and saturated result from stage 1
  always_comb begin
    sum_next   = '0;
    carry_next = '0;
    pos_next   = '0;
    neg_next   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_tc) begin
        // Signed overflow: operands of the sign that can overflow, and a
        // result MSB that disagrees with them.
        if (s1_addsub) begin
          pos_next[i] = ~s1_a_msb[i] &  s1_b_msb[i] &  s1_raw[i][WIDTH-1];
          neg_next[i] =  s1_a_msb[i] & ~s1_b_msb[i] & ~s1_raw[i][WIDTH-1];
        end else begin
          pos_next[i] = ~s1_a_msb[i] & ~s1_b_msb[i] &  s1_raw[i][WIDTH-1];
          neg_next[i] =  s1_a_msb[i] &  s1_b_msb[i] & ~s1_raw[i][WIDTH-1];
        end
        // Sign-extension bit of the exact result; b is inverted for subtract.
        carry_next[i] = s1_raw[i][WIDTH] ^ s1_a_msb[i] ^ (s1_b_msb[i] ^ s1_addsub);
      end else begin
        // Unsigned: carry-out overflows an add, a missing carry (borrow)
        // underflows a subtract.
        pos_next[i]   = ~s1_addsub &  s1_raw[i][WIDTH];
        neg_next[i]   =  s1_addsub & ~s1_raw[i][WIDTH];
        carry_next[i] = s1_raw[i][WIDTH] ^ s1_addsub;
        if (s1_sat & (pos_next[i] | neg_next[i]))
          carry_next[i] = 1'b0;
      end
      sum_next[i*WIDTH +: WIDTH] = s1_raw[i][WIDTH-1:0];
      if (s1_sat & pos_next[i])
        sum_next[i*WIDTH +: WIDTH] = s1_tc ? TC_MAX : '1;
      else if (s1_sat & neg_next[i])
        sum_next[i*WIDTH +: WIDTH] = s1_tc ? TC_MIN : '0;
    end
  end

  // Pipeline valid bits; reset discards anything in flight
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples values from before the clock edge.
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid  <= in_valid;
      if (adv2)     out_valid <= s1_valid;
    end
  end

  // Stage 1 data capture
  always_ff @(posedge clk) begin
    // NOTE: datapath registers behind a valid bit need no reset; the valid bit
    // alone decides whether their contents are ever used.
    if (in_valid & in_ready) begin
      s1_raw    <= raw_next;
      s1_a_msb  <= a_msb;
      s1_b_msb  <= b_msb;
      s1_addsub <= addsub;
      s1_tc     <= tc;
      s1_sat    <= sat;
    end
  end

  // Output registers: reset to zero, otherwise load when stage 1 advances
  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      carry   <= '0;
      ovf_pos <= '0;
      ovf_neg <= '0;
    end else if (adv2 & s1_valid) begin
      sum     <= sum_next;
      carry   <= carry_next;
      ovf_pos <= pos_next;
      ovf_neg <= neg_next;
    end
  end

`ifdef SAT_STICKY_EN
  // Sticky overflow: a flagged output transfer wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)
      sticky <= '0;
    else
      sticky <= (sticky & ~{LANES{sticky_clr}})
              | ((out_valid & out_ready) ? (ovf_pos | ovf_neg) : '0);
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky            = '0;
`endif

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Self-checking bench for sat_addsub_pipe: directed test-plan cases, back-
// pressure, sticky behaviour, mid-stream reset and randomized traffic, all
// compared against an integer-arithmetic reference model and a result queue.
module tb_sat_addsub_pipe;

  localparam int W = 8;
  localparam int L = 4;
`ifdef SAT_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic           addsub;
    logic           tc;
    logic           sat;
  } item_t;

  typedef struct packed {
    logic [L*W-1:0] sum;
    logic [L-1:0]   carry;
    logic [L-1:0]   pos;
    logic [L-1:0]   neg;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [L*W-1:0] a, b;
  logic           addsub, tc, sat;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] sum;
  logic [L-1:0]   carry, ovf_pos, ovf_neg, sticky;
  logic           sticky_clr;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc_cyc;
  bit   rnd    = 1'b0;
  exp_t q[$];
  logic [L-1:0] m_sticky = '0;
  logic [L-1:0] nxt;

  sat_addsub_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .addsub(addsub), .tc(tc), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
    .ovf_pos(ovf_pos), .ovf_neg(ovf_neg), .sticky(sticky), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer result per lane, compared with the mode's range.
  function automatic exp_t model(input item_t it);
    exp_t e;
    e = '0;
    for (int l = 0; l < L; l++) begin
      int ua, ub, sa, sb, full, lo, hi, r;
      logic [W-1:0] rv;
      ua = int'(it.a[l*W +: W]);
      ub = int'(it.b[l*W +: W]);
      sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
      sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
      if (it.tc) begin
        full = it.addsub ? sa - sb : sa + sb;
        lo = -(2**(W-1));
        hi = 2**(W-1) - 1;
      end else begin
        full = it.addsub ? ua - ub : ua + ub;
        lo = 0;
        hi = 2**W - 1;
      end
      e.pos[l] = (full > hi);
      e.neg[l] = (full < lo);
      r = full;
      if (it.sat && e.pos[l]) r = hi;
      if (it.sat && e.neg[l]) r = lo;
      rv = W'(r);
      e.sum[l*W +: W] = rv;
      if (it.tc)
        e.carry[l] = full[W];
      else
        e.carry[l] = (it.sat && (e.pos[l] || e.neg[l])) ? 1'b0 : (e.pos[l] || e.neg[l]);
    end
    return e;
  endfunction

  // Output monitor: every valid output must match the oldest outstanding result
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_sticky = '0;
    end else begin
      check("sticky", sticky, m_sticky);
      nxt = sticky_clr ? '0 : m_sticky;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("sum", sum, q[0].sum);
          check("carry", carry, q[0].carry);
          check("ovf_pos", ovf_pos, q[0].pos);
          check("ovf_neg", ovf_neg, q[0].neg);
          if (out_ready) begin
            if (STK) nxt = nxt | q[0].pos | q[0].neg;
            void'(q.pop_front());
          end
        end
      end
      m_sticky = nxt;
    end
  end

  task automatic drive(input item_t it);
    a = it.a; b = it.b; addsub = it.addsub; tc = it.tc; sat = it.sat;
  endtask

  // Offer one item and hold it until accepted (bounded)
  task automatic send(input item_t it);
    int waited = 0;
    in_valid = 1'b1;
    drive(it);
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(it));
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) begin
          out_ready  = ($urandom_range(0, 3) != 0);
          sticky_clr = ($urandom_range(0, 15) == 0);
        end
        return;
      end
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        sticky_clr = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);
  endtask

  function automatic item_t mk(input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic s, input logic t, input logic st);
    item_t it;
    it = '0;
    it.a[W-1:0] = a0; it.b[W-1:0] = b0;
    it.a[2*W-1:W] = a1; it.b[2*W-1:W] = b1;
    it.addsub = s; it.tc = t; it.sat = st;
    return it;
  endfunction

  // Directed case: one transfer through an empty pipe, checked against constants
  task automatic run_dir(input string name, input item_t it, input logic [L*W-1:0] es,
                         input logic [L-1:0] ec, input logic [L-1:0] ep, input logic [L-1:0] en);
    drain();
    send(it);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_sum"}, sum, es);
    check({name, "_carry"}, carry, ec);
    check({name, "_pos"}, ovf_pos, ep);
    check({name, "_neg"}, ovf_neg, en);
    @(posedge clk); #1;
  endtask

  item_t bp[4];
  item_t ovf_it;
  int    idx;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; addsub = 1'b0; tc = 1'b0;
    sat = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_carry", carry, '0);
    check("rst_ovf", {ovf_pos, ovf_neg}, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Test-plan arithmetic cases (lane 0 exercised, lane 1 5+3 in add cases)
    run_dir("uadd_sat",  mk(8'd200, 8'd100, 8'd5, 8'd3, 0, 0, 1), 32'h0000_08FF, 4'b0000, 4'b0001, 4'b0000);
    run_dir("uadd_wrap", mk(8'd200, 8'd100, 8'd5, 8'd3, 0, 0, 0), 32'h0000_082C, 4'b0001, 4'b0001, 4'b0000);
    run_dir("usub_sat",  mk(8'd10, 8'd20, 8'd0, 8'd0, 1, 0, 1),   32'h0000_0000, 4'b0000, 4'b0000, 4'b0001);
    run_dir("usub_wrap", mk(8'd10, 8'd20, 8'd0, 8'd0, 1, 0, 0),   32'h0000_00F6, 4'b0001, 4'b0000, 4'b0001);
    run_dir("tadd_sat",  mk(8'd100, 8'd100, 8'd0, 8'd0, 0, 1, 1), 32'h0000_007F, 4'b0000, 4'b0001, 4'b0000);
    run_dir("tsub_sat",  mk(8'h80, 8'h01, 8'd0, 8'd0, 1, 1, 1),   32'h0000_0080, 4'b0001, 4'b0000, 4'b0001);
    run_dir("tadd_zero", mk(8'hFF, 8'h01, 8'd0, 8'd0, 0, 1, 1),   32'h0000_0000, 4'b0000, 4'b0000, 4'b0000);

    // Back-pressure: four back-to-back offers with the consumer stalled
    drain();
    for (int i = 0; i < 4; i++) bp[i] = mk(8'(i*40+7), 8'(i*3+1), 8'(i), 8'(250), 0, 0, i[0]);
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(bp[idx]);
      @(negedge clk);
      if (in_ready) begin q.push_back(model(bp[idx])); idx++; end
      @(posedge clk); #1;
    end
    check("bp_accepted", idx, 2);
    drive(bp[idx]);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) begin in_valid = 1'b1; drive(bp[idx]); end
      else in_valid = 1'b0;
      @(negedge clk);
      check("bp_no_gap", out_valid, 1'b1);
      if (in_valid && in_ready) begin q.push_back(model(bp[idx])); idx++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    drain();

    // Sticky: set by an overflow, survives a same-cycle clear, cleared alone
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    ovf_it = mk(8'd200, 8'd100, 8'd0, 8'd0, 0, 0, 1);
    send(ovf_it);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("sticky_set", sticky[0], STK);
    @(posedge clk); #1;
    send(ovf_it);
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", sticky[0], STK);
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", sticky, '0);
    @(posedge clk); #1;

    // Randomized traffic with random stalls and occasional sticky clears
    rnd = 1'b1;
    for (int n = 0; n < 300; n++) begin
      item_t it;
      it.a = $urandom; it.b = $urandom;
      it.addsub = 1'($urandom); it.tc = 1'($urandom); it.sat = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      send(it);
    end
    rnd = 1'b0;
    sticky_clr = 1'b0;
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(mk(8'd1, 8'd2, 8'd3, 8'd4, 0, 0, 0));
    send(mk(8'd200, 8'd100, 8'd3, 8'd4, 0, 0, 1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_sticky", sticky, '0);
    repeat (3) @(negedge clk);
    check("midrst_no_stale", out_valid, 1'b0);
    @(posedge clk); #1;
    send(mk(8'd100, 8'd27, 8'd9, 8'd9, 0, 1, 1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("midrst_latency", cyc - acc_cyc, 2);
    @(posedge clk); #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
